// File: rtl/point_detect.sv
// Rally rule engine: detects goal-line crossings once per frame, emits one-cycle score pulses
// and sequences serve hold/direction. Define WIN_LIMIT_EN to add match tallies and a game-over state.
module point_detect #(
    parameter int X_W          = 10,
    parameter int LEFT_GOAL    = 0,
    parameter int RIGHT_GOAL   = 632,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 9
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           frame_tick,
    input  logic           start,
    input  logic [X_W-1:0] ball_x,
    output logic           p1_point,
    output logic           p2_point,
    output logic           ball_hold,
    output logic           serve_dir,
    output logic           game_over
);

    localparam int             CNT_W    = (SERVE_FRAMES < 2) ? 1 : $clog2(SERVE_FRAMES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((SERVE_FRAMES == 0) ? 0 : SERVE_FRAMES - 1);
    localparam logic [X_W-1:0] LEFT_X   = X_W'(LEFT_GOAL);
    localparam logic [X_W-1:0] RIGHT_X  = X_W'(RIGHT_GOAL);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SERVE,
        S_PLAY,
        S_POINT
`ifdef WIN_LIMIT_EN
        , S_OVER
`endif
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             p1_n, p2_n, dir_n;

`ifdef WIN_LIMIT_EN
    localparam logic [3:0] WIN_T = 4'(WIN_SCORE);
    logic [3:0] tally1, tally2, tally1_n, tally2_n;
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        p1_n    = 1'b0;
        p2_n    = 1'b0;
        dir_n   = serve_dir;
`ifdef WIN_LIMIT_EN
        tally1_n = tally1;
        tally2_n = tally2;
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_SERVE;
                    cnt_n   = '0;
                end
            end
            S_SERVE: begin
                // A zero-length serve still spends one cycle here so pulses stay spaced
                if (SERVE_FRAMES == 0) begin
                    state_n = S_PLAY;
                end else if (frame_tick) begin
                    if (cnt == CNT_LAST) state_n = S_PLAY;
                    else                 cnt_n   = cnt + 1'b1;
                end
            end
            S_PLAY: begin
                if (frame_tick) begin
                    if (ball_x <= LEFT_X) begin
                        state_n = S_POINT;
                        p2_n    = 1'b1;
                        dir_n   = 1'b0;
                    end else if (ball_x >= RIGHT_X) begin
                        state_n = S_POINT;
                        p1_n    = 1'b1;
                        dir_n   = 1'b1;
                    end
                end
            end
            S_POINT: begin
                state_n = S_SERVE;
                cnt_n   = '0;
`ifdef WIN_LIMIT_EN
                // Tallies were already bumped on entry to POINT
                if (tally1 == WIN_T || tally2 == WIN_T) state_n = S_OVER;
`endif
            end
`ifdef WIN_LIMIT_EN
            S_OVER: begin
                if (start) begin
                    state_n  = S_SERVE;
                    cnt_n    = '0;
                    tally1_n = '0;
                    tally2_n = '0;
                end
            end
`endif
            default: state_n = S_IDLE;
        endcase
`ifdef WIN_LIMIT_EN
        if (p1_n) tally1_n = tally1 + 4'd1;
        if (p2_n) tally2_n = tally2 + 4'd1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            p1_point  <= 1'b0;
            p2_point  <= 1'b0;
            ball_hold <= 1'b1;
            serve_dir <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            p1_point  <= p1_n;
            p2_point  <= p2_n;
            ball_hold <= (state_n != S_PLAY);
            serve_dir <= dir_n;
        end
    end

`ifdef WIN_LIMIT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tally1    <= '0;
            tally2    <= '0;
            game_over <= 1'b0;
        end else begin
            tally1    <= tally1_n;
            tally2    <= tally2_n;
            game_over <= (state_n == S_OVER);
        end
    end
`else
    assign game_over = 1'b0;
`endif

endmodule
